trace_packer: RTL and testbench
===============================

Name: trace_packer

Overview:
- Tracer stage directly upstream of the trace logger.
- Capture mode: samples 1..TRB_MAX_TRACES DUT trace lanes per cycle, packs them LSB-first into TRB_WIDTH words, and hands each full word to the logger with a one-cycle store strobe.
- Also detects the first trigger edge and reports its bit position inside the current word.
- Streaming mode: requests words from the logger and replays them lane-wise onto a stream output.

Parameters:
- TRB_WIDTH, 32, memory word width in bits; must be a multiple of TRB_MAX_TRACES.
- TRB_MAX_TRACES, 8, maximum parallel trace lanes; must be a power of two, >= 2.

Ports:
- CLK_I  in  1  sole clock.
- RST_I  in  1  reset, asynchronous, active-high.
- ENABLE_I  in  1  run enable; low forces IDLE.
- MODE_I  in  1  0 = trace-buffer capture, 1 = streaming.
- NTRACE_I  in  $clog2(TRB_MAX_TRACES)  lane code; lanes L = 2**min(NTRACE_I, log2(TRB_MAX_TRACES)).
- TRACE_I  in  TRB_MAX_TRACES  trace sample; only bits [L-1:0] are used.
- TRG_I  in  1  DUT trigger level.
- TRG_DELAYED_I  in  1  from logger: trigger seen and post-trigger delay expired.
- STORE_O  out  1  one-cycle strobe; DATA_O holds a complete word.
- DATA_O  out  TRB_WIDTH  packed word.
- TRG_EVENT_O  out  1  sticky: first trigger registered.
- EVENT_POS_O  out  $clog2(TRB_WIDTH)  bit index of the triggering sample.
- REQ_O  out  1  streaming: request one word.
- LOAD_I  in  1  streaming: DATA_I is valid this cycle.
- DATA_I  in  TRB_WIDTH  streaming word from logger.
- STREAM_O  out  TRB_MAX_TRACES  streamed lanes; bits >= L are 0.
- STREAM_VALID_O  out  1  STREAM_O is valid.

Behaviour:
- Reset: all outputs 0, state IDLE, fill index 0, both stream buffers empty.
- States: IDLE, CAPTURE, DRAIN, DONE, STREAM.
- Leaving IDLE:
  - IDLE with ENABLE_I=1 latches MODE_I and L.
  - Next state is CAPTURE if MODE_I=0, otherwise STREAM.
  - MODE_I and NTRACE_I are ignored outside IDLE.
- ENABLE_I=0 in any state:
  - Next cycle enters IDLE.
  - Partial word discarded, fill index cleared, TRG_EVENT_O cleared, stream buffers flushed.
  - No STORE_O is issued.
- Packing (CAPTURE and DRAIN):
  - Each cycle, TRACE_I[L-1:0] is written at bits [idx +: L]; idx then advances by L.
  - When idx+L == TRB_WIDTH, the next cycle carries STORE_O=1 and DATA_O = the completed word, and idx returns to 0.
  - The sample in that same cycle goes into a fresh word, so there are no bubbles.
  - DATA_O holds its value until the next store.
- Trigger:
  - The first CAPTURE-cycle TRG_I=1 while TRG_EVENT_O=0 sets TRG_EVENT_O next cycle.
  - EVENT_POS_O is set to the idx at which that cycle's sample was written.
  - Later triggers are ignored.
  - TRG_I in DRAIN, DONE or STREAM is ignored.
- TRG_DELAYED_I=1 in CAPTURE moves to DRAIN.
- DRAIN:
  - Keeps sampling until the current word completes, issues its STORE_O, then enters DONE.
  - If idx==0 on entry, the word then being started is completed; the block never stores a partial word.
- DONE: no stores; outputs hold; exit only via ENABLE_I=0.
- Streaming: two word buffers, shift (S) and next (N).
  - REQ_O is a one-cycle pulse whenever N is empty and no request is outstanding.
  - At most one request is outstanding.
  - LOAD_I fills N; LOAD_I with no request outstanding is ignored.
  - When S is empty and N is full, N moves to S in one cycle.
  - While S is full, each cycle drives STREAM_O[L-1:0] = S[pos +: L] with STREAM_VALID_O=1, and pos advances by L.
  - S empties after TRB_WIDTH/L beats.
  - Underrun: STREAM_VALID_O=0 and STREAM_O=0.
  - Steady-state throughput is one word per TRB_WIDTH/L cycles, provided logger latency < TRB_WIDTH/L.
- STORE_O is never asserted in STREAM; REQ_O is never asserted in CAPTURE, DRAIN or DONE.

Decomposition:
- DTB_PKG holds TRB_WIDTH, TRB_MAX_TRACES, the lane-code-to-L function, and the enum packer_state_t {IDLE, CAPTURE, DRAIN, DONE, STREAM}.
- One sub-module: lane_shifter.
  - Parameterised insert/extract of L bits at a bit index in a TRB_WIDTH word.
  - Used by both packing and streaming.

Test Plan:
- Packing, L=4: NTRACE_I=2, ENABLE_I=1, MODE_I=0, TRACE_I=0..7 over 8 cycles -> one STORE_O pulse, DATA_O=32'h76543210, then the next word starts with no gap.
- Trigger position, L=1: TRACE_I=1 constant, TRG_I pulsed on the 13th capture cycle -> TRG_EVENT_O=1, EVENT_POS_O=12; a second TRG_I pulse leaves EVENT_POS_O=12.
- Drain, L=8: TRG_DELAYED_I asserted after 1 sample of a word -> exactly 3 more samples, one STORE_O, then DONE with no further stores over 20 cycles.
- Abort: ENABLE_I dropped mid-word -> no STORE_O, IDLE next cycle; re-enable gives fill starting at bit 0 and TRG_EVENT_O=0.
- Streaming, L=8: logger returns 32'hDDCCBBAA with LOAD_I 2 cycles after each REQ_O -> STREAM_O sequence AA,BB,CC,DD with continuous STREAM_VALID_O after the first word, and never more than one outstanding REQ_O.
- Async reset: assert RST_I mid-word between clock edges -> all outputs 0 immediately (before the next edge); state IDLE after release.

Source files
------------

// File: rtl/trace_packer_pkg.sv
// Shared constants, lane-code decode and state encoding
// for the trace packer.
package trace_packer_pkg;

  localparam int TRB_WIDTH      = 32;
  localparam int TRB_MAX_TRACES = 8;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE,
    STREAM
  } packer_state_t;

  // Lane code saturates at the widest configuration.
  function automatic int unsigned lanes_of(
    input int unsigned code,
    input int unsigned max_log
  );
    int unsigned e;
    e = (code > max_log) ? max_log : code;
    return 32'd1 << e;
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// Inserts or extracts an L-bit lane group at a bit
// index inside a memory word.
module lane_shifter
  import trace_packer_pkg::*;
#(
  parameter int W = TRB_WIDTH,
  parameter int N = TRB_MAX_TRACES
) (
  input  logic [W-1:0]         word,
  input  logic [$clog2(N):0]   lanes,
  input  logic [$clog2(W)-1:0] idx,
  input  logic [N-1:0]         din,
  output logic [W-1:0]         word_ins,
  output logic [N-1:0]         dout
);

  logic [N-1:0] mask;
  logic [W-1:0] mask_w;
  logic [W-1:0] din_w;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = (i < int'(lanes));
  end

  assign mask_w   = W'(mask) << idx;
  assign din_w    = W'(din & mask) << idx;
  assign word_ins = (word & ~mask_w) | din_w;
  assign dout     = N'(word >> idx) & mask;

endmodule

// File: rtl/trace_packer.sv
// Trace capture packer and word-to-lane streamer
// sitting in front of the trace logger.
module trace_packer
  import trace_packer_pkg::*;
#(
  parameter int TRB_WIDTH      = trace_packer_pkg::TRB_WIDTH,
  parameter int TRB_MAX_TRACES = trace_packer_pkg::TRB_MAX_TRACES
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  input  logic                              ENABLE_I,
  input  logic                              MODE_I,
  input  logic [$clog2(TRB_MAX_TRACES)-1:0] NTRACE_I,
  input  logic [TRB_MAX_TRACES-1:0]         TRACE_I,
  input  logic                              TRG_I,
  input  logic                              TRG_DELAYED_I,
  output logic                              STORE_O,
  output logic [TRB_WIDTH-1:0]              DATA_O,
  output logic                              TRG_EVENT_O,
  output logic [$clog2(TRB_WIDTH)-1:0]      EVENT_POS_O,
  output logic                              REQ_O,
  input  logic                              LOAD_I,
  input  logic [TRB_WIDTH-1:0]              DATA_I,
  output logic [TRB_MAX_TRACES-1:0]         STREAM_O,
  output logic                              STREAM_VALID_O
);

  localparam int W  = TRB_WIDTH;
  localparam int N  = TRB_MAX_TRACES;
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(N);
  localparam int LW = CW + 1;

  packer_state_t state_q, state_d;

  logic [LW-1:0] lanes_q;
  logic [IW-1:0] idx_q;
  logic [IW:0]   idx_nx;
  logic          wrap;
  logic          last_beat;
  logic          load_ok;
  logic [W-1:0]  word_q;
  logic [W-1:0]  s_buf_q;
  logic [W-1:0]  n_buf_q;
  logic [W-1:0]  sh_word;
  logic [W-1:0]  ins_word;
  logic [N-1:0]  ext;
  logic          s_full_q;
  logic          n_full_q;
  logic          pend_q;
  logic          store_q;
  logic [W-1:0]  data_q;
  logic          trg_q;
  logic [IW-1:0] pos_q;

  // One index serves as fill index and stream position.
  assign idx_nx    = {1'b0, idx_q} + (IW+1)'(lanes_q);
  assign wrap      = idx_nx == (IW+1)'(W);
  assign last_beat = s_full_q && wrap;
  assign load_ok   = LOAD_I && pend_q;
  assign sh_word   = (state_q == STREAM) ? s_buf_q : word_q;

  lane_shifter #(
    .W(W),
    .N(N)
  ) u_shift (
    .word    (sh_word),
    .lanes   (lanes_q),
    .idx     (idx_q),
    .din     (TRACE_I),
    .word_ins(ins_word),
    .dout    (ext)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (ENABLE_I)
          state_d = MODE_I ? STREAM : CAPTURE;
      CAPTURE:
        if (TRG_DELAYED_I) state_d = DRAIN;
      DRAIN:
        if (wrap) state_d = DONE;
      default: ;
    endcase
    if (!ENABLE_I) state_d = IDLE;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      lanes_q  <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      s_buf_q  <= '0;
      n_buf_q  <= '0;
      s_full_q <= 1'b0;
      n_full_q <= 1'b0;
      pend_q   <= 1'b0;
      store_q  <= 1'b0;
      data_q   <= '0;
      trg_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      store_q <= 1'b0;
      if (!ENABLE_I) begin
        idx_q    <= '0;
        word_q   <= '0;
        trg_q    <= 1'b0;
        s_full_q <= 1'b0;
        n_full_q <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            lanes_q <= LW'(lanes_of(32'(NTRACE_I), CW));
            idx_q   <= '0;
            word_q  <= '0;
          end
          CAPTURE, DRAIN: begin
            if (state_q == CAPTURE && TRG_I && !trg_q) begin
              trg_q <= 1'b1;
              pos_q <= idx_q;
            end
            if (wrap) begin
              data_q  <= ins_word;
              store_q <= 1'b1;
              word_q  <= '0;
              idx_q   <= '0;
            end else begin
              word_q <= ins_word;
              idx_q  <= idx_nx[IW-1:0];
            end
          end
          STREAM: begin
            if (REQ_O) pend_q <= 1'b1;
            // A word landing on the last beat bypasses N.
            if (s_full_q) begin
              if (wrap) begin
                idx_q <= '0;
                if (n_full_q) begin
                  s_buf_q  <= n_buf_q;
                  n_full_q <= 1'b0;
                end else if (load_ok) begin
                  s_buf_q <= DATA_I;
                  pend_q  <= 1'b0;
                end else begin
                  s_full_q <= 1'b0;
                end
              end else begin
                idx_q <= idx_nx[IW-1:0];
              end
            end else if (n_full_q) begin
              s_buf_q  <= n_buf_q;
              s_full_q <= 1'b1;
              n_full_q <= 1'b0;
            end
            if (load_ok && !last_beat) begin
              n_buf_q  <= DATA_I;
              n_full_q <= 1'b1;
              pend_q   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign STORE_O        = store_q;
  assign DATA_O         = data_q;
  assign TRG_EVENT_O    = trg_q;
  assign EVENT_POS_O    = pos_q;
  assign REQ_O          = (state_q == STREAM) && !n_full_q && !pend_q;
  assign STREAM_VALID_O = s_full_q;
  assign STREAM_O       = s_full_q ? ext : '0;

endmodule

// File: tb/tb_trace_packer.sv
// Self-checking bench for trace_packer: directed tables,
// corner sequences and randomized capture/stream runs.
module tb_trace_packer;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        ENABLE_I;
  logic        MODE_I;
  logic [2:0]  NTRACE_I;
  logic [7:0]  TRACE_I;
  logic        TRG_I;
  logic        TRG_DELAYED_I;
  logic        STORE_O;
  logic [31:0] DATA_O;
  logic        TRG_EVENT_O;
  logic [4:0]  EVENT_POS_O;
  logic        REQ_O;
  logic        LOAD_I;
  logic [31:0] DATA_I;
  logic [7:0]  STREAM_O;
  logic        STREAM_VALID_O;

  int checks = 0;
  int errors = 0;

  trace_packer dut (
    .CLK_I         (CLK_I),
    .RST_I         (RST_I),
    .ENABLE_I      (ENABLE_I),
    .MODE_I        (MODE_I),
    .NTRACE_I      (NTRACE_I),
    .TRACE_I       (TRACE_I),
    .TRG_I         (TRG_I),
    .TRG_DELAYED_I (TRG_DELAYED_I),
    .STORE_O       (STORE_O),
    .DATA_O        (DATA_O),
    .TRG_EVENT_O   (TRG_EVENT_O),
    .EVENT_POS_O   (EVENT_POS_O),
    .REQ_O         (REQ_O),
    .LOAD_I        (LOAD_I),
    .DATA_I        (DATA_I),
    .STREAM_O      (STREAM_O),
    .STREAM_VALID_O(STREAM_VALID_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [7:0]  trace;
    logic        store;
    logic [31:0] data;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_store"}, STORE_O, 0);
    chk({nm, "_data"}, DATA_O, 0);
    chk({nm, "_trg"}, TRG_EVENT_O, 0);
    chk({nm, "_pos"}, EVENT_POS_O, 0);
    chk({nm, "_req"}, REQ_O, 0);
    chk({nm, "_stream"}, STREAM_O, 0);
    chk({nm, "_valid"}, STREAM_VALID_O, 0);
  endtask

  task automatic restart();
    ENABLE_I = 1'b0;
    TRG_I = 1'b0;
    TRG_DELAYED_I = 1'b0;
    LOAD_I = 1'b0;
    step();
  endtask

  task automatic start(input bit mode, input logic [2:0] code);
    ENABLE_I = 1'b1;
    MODE_I = mode;
    NTRACE_I = code;
    step();
  endtask

  task automatic test_pack();
    vec_t tv[16];
    for (int i = 0; i < 16; i++) begin
      tv[i].trace = {4'(15 - i), 4'(i)};
      tv[i].store = (i == 7) || (i == 15);
      tv[i].data  = (i < 7)  ? 32'h0 :
                    (i < 15) ? 32'h76543210 : 32'hFEDCBA98;
    end
    restart();
    start(1'b0, 3'd2);
    for (int i = 0; i < 16; i++) begin
      TRACE_I = tv[i].trace;
      step();
      chk($sformatf("pack_store%0d", i), STORE_O, tv[i].store);
      chk($sformatf("pack_data%0d", i), DATA_O, tv[i].data);
    end
  endtask

  task automatic test_trig();
    restart();
    TRACE_I = 8'hFF;
    start(1'b0, 3'd0);
    for (int c = 1; c <= 32; c++) begin
      TRG_I = (c == 13) || (c == 20);
      step();
      if (c == 12) chk("trg_before", TRG_EVENT_O, 0);
      if (c == 13) begin
        chk("trg_set", TRG_EVENT_O, 1);
        chk("trg_pos", EVENT_POS_O, 12);
      end
      if (c == 21) chk("trg_pos_kept", EVENT_POS_O, 12);
      if (c == 32) begin
        chk("trg_word_store", STORE_O, 1);
        chk("trg_word_data", DATA_O, 32'hFFFFFFFF);
      end
    end
    TRG_I = 1'b0;
  endtask

  task automatic test_drain();
    int stores = 0;
    int reqs = 0;
    restart();
    start(1'b0, 3'd3);
    TRACE_I = 8'h11; step();
    chk("drain_s1", STORE_O, 0);
    TRACE_I = 8'h22; TRG_DELAYED_I = 1'b1; step();
    TRG_DELAYED_I = 1'b0;
    chk("drain_s2", STORE_O, 0);
    TRACE_I = 8'h33; step();
    chk("drain_s3", STORE_O, 0);
    TRACE_I = 8'h44; step();
    chk("drain_store", STORE_O, 1);
    chk("drain_data", DATA_O, 32'h44332211);
    TRG_I = 1'b1;
    for (int i = 0; i < 20; i++) begin
      TRACE_I = 8'($urandom);
      step();
      stores += int'(STORE_O);
      reqs += int'(REQ_O);
    end
    TRG_I = 1'b0;
    chk("done_no_store", stores, 0);
    chk("done_no_req", reqs, 0);
    chk("done_data_hold", DATA_O, 32'h44332211);
    chk("done_trg_ignored", TRG_EVENT_O, 0);
  endtask

  task automatic test_abort();
    restart();
    start(1'b0, 3'd2);
    TRACE_I = 8'h09;
    TRG_I = 1'b1; step(); TRG_I = 1'b0;
    chk("abort_trg_set", TRG_EVENT_O, 1);
    step(); step();
    ENABLE_I = 1'b0; step();
    chk("abort_no_store", STORE_O, 0);
    chk("abort_trg_clr", TRG_EVENT_O, 0);
    TRACE_I = 8'h0F;
    start(1'b0, 3'd2);
    chk("reen_trg", TRG_EVENT_O, 0);
    for (int i = 1; i <= 8; i++) begin
      TRACE_I = 8'(i);
      step();
      chk($sformatf("reen_store%0d", i), STORE_O, i == 8);
    end
    chk("reen_data", DATA_O, 32'h87654321);
  endtask

  task automatic run_stream(input int code, input int lat,
                            input int ncyc, input bit fixed);
    int L;
    int cnt = 0;
    int outst = 0;
    bit seen = 0;
    logic [7:0] q[$];
    logic [31:0] w;
    L = 1 << ((code > 3) ? 3 : code);
    restart();
    start(1'b1, 3'(code));
    for (int k = 0; k < ncyc; k++) begin
      chk("stream_store", STORE_O, 0);
      if (STREAM_VALID_O) begin
        seen = 1;
        if (q.size() == 0) chk("stream_nodata", STREAM_VALID_O, 0);
        else chk("stream_lane", STREAM_O, q.pop_front());
      end else begin
        chk("stream_gap", seen, 0);
        chk("stream_idle_zero", STREAM_O, 0);
      end
      LOAD_I = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          w = fixed ? 32'hDDCCBBAA : $urandom;
          DATA_I = w;
          LOAD_I = 1'b1;
          outst--;
          for (int p = 0; p < 32; p += L)
            q.push_back(8'((w >> p) & ((1 << L) - 1)));
        end
      end
      if (REQ_O) begin
        outst++;
        chk("one_outstanding", outst <= 1, 1);
        cnt = lat;
      end
      step();
    end
    LOAD_I = 1'b0;
    chk("stream_started", seen, 1);
  endtask

  task automatic run_capture(input int code, input int ncyc);
    int L;
    bit bits[$];
    bit trg_seen = 0;
    int trg_pos = 0;
    bit have = 0;
    logic [31:0] last = '0;
    logic [31:0] w;
    logic [7:0] tr;
    bit trg;
    bit exp_store;
    L = 1 << ((code > 3) ? 3 : code);
    restart();
    start(1'b0, 3'(code));
    for (int k = 0; k < ncyc; k++) begin
      tr = 8'($urandom);
      trg = ($urandom_range(0, 15) == 0);
      TRACE_I = tr;
      TRG_I = trg;
      step();
      if (trg && !trg_seen) begin
        trg_seen = 1;
        trg_pos = bits.size();
      end
      for (int b = 0; b < L; b++) bits.push_back(tr[b]);
      exp_store = 0;
      if (bits.size() == 32) begin
        for (int i = 0; i < 32; i++) w[i] = bits[i];
        last = w;
        have = 1;
        exp_store = 1;
        bits.delete();
      end
      chk("rc_store", STORE_O, exp_store);
      chk("rc_trg", TRG_EVENT_O, trg_seen);
      chk("rc_req", REQ_O, 0);
      if (trg_seen) chk("rc_pos", EVENT_POS_O, trg_pos);
      if (have) chk("rc_data", DATA_O, last);
    end
    TRG_I = 1'b0;
    ENABLE_I = 1'b0;
    step();
    chk("rc_abort_store", STORE_O, 0);
    chk("rc_abort_trg", TRG_EVENT_O, 0);
  endtask

  task automatic test_async_reset();
    restart();
    start(1'b0, 3'd2);
    TRACE_I = 8'h03;
    for (int i = 0; i < 10; i++) begin
      TRG_I = (i == 1);
      step();
    end
    TRG_I = 1'b0;
    chk("ar_pre_trg", TRG_EVENT_O, 1);
    chk("ar_pre_pos", EVENT_POS_O, 4);
    chk("ar_pre_data", DATA_O, 32'h33333333);
    #2 RST_I = 1'b1;
    #1 chk_all_zero("ar");
    MODE_I = 1'b1;
    NTRACE_I = 3'd3;
    #1 RST_I = 1'b0;
    step();
    chk("ar_idle_then_stream", REQ_O, 1);
  endtask

  initial begin
    RST_I = 1'b1;
    ENABLE_I = 1'b0;
    MODE_I = 1'b0;
    NTRACE_I = '0;
    TRACE_I = '0;
    TRG_I = 1'b0;
    TRG_DELAYED_I = 1'b0;
    LOAD_I = 1'b0;
    DATA_I = '0;
    #12;
    chk_all_zero("reset");
    @(negedge CLK_I);
    RST_I = 1'b0;

    test_pack();
    test_trig();
    test_drain();
    test_abort();
    run_stream(3, 2, 30, 1'b1);
    for (int r = 0; r < 5; r++) begin
      int code;
      int L;
      int mx;
      code = $urandom_range(0, 7);
      L = 1 << ((code > 3) ? 3 : code);
      mx = (32 / L - 2 > 6) ? 6 : 32 / L - 2;
      run_stream(code, 1 + $urandom_range(0, mx), 80, 1'b0);
    end
    for (int r = 0; r < 6; r++)
      run_capture($urandom_range(0, 7), $urandom_range(40, 100));
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
